frame_draw_ctrl: RTL and testbench
==================================

# frame_draw_ctrl

Full-screen redraw sequencer between the game FSM and the 160x120 VGA adapter. On a start request it sweeps every pixel once: it drives a shared address to the background ROMs (start, game, end screens) or a solid fill colour, aligns ROM read latency, and emits one x/y/colour/plot write per pixel. It signals busy during the sweep and pulses done at completion. It owns the adapter's write port whenever busy.

## Interface
- WIDTH, 160, pixels per row
- HEIGHT, 120, rows per frame
- ADDR_WIDTH, 15, ROM address width; must hold WIDTH*HEIGHT-1
- ROM_LATENCY, 1, ROM read latency in cycles (1 or 2)

- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  redraw request, sampled only in IDLE
- abort  in  1  cancel current sweep, no done pulse
- scene  in  2  source select, latched on accepted start: 0 start ROM, 1 game ROM, 2 end ROM, 3 fill_colour
- fill_colour  in  12  RGB444 solid colour, latched on accepted start
- start_q, game_q, end_q  in  12 each  ROM data outputs
- rom_address  out  ADDR_WIDTH  shared ROM address
- x  out  8  pixel column to adapter
- y  out  7  pixel row to adapter
- colour  out  12  pixel colour to adapter
- plot  out  1  adapter write enable
- busy  out  1  high from sweep start until done cycle
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: busy=0. start=1 and abort=0 -> latch scene/fill_colour, zero address and x/y counters, go FETCH. abort=1 in the same cycle wins: start ignored.
- FETCH: rom_address steps 0..N-1 (N=WIDTH*HEIGHT), one per cycle. Issue x/y counters: x increments and wraps WIDTH-1 -> 0 with y+1. Address built incrementally with no multiplier; address equals y*WIDTH+x. After issuing N-1, go DRAIN.
- DRAIN: no new addresses; rom_address returns to 0. Wait until the last pixel leaves the pipeline, then go DONE.
- DONE: one cycle, done=1, busy=0, then IDLE. start during DONE is ignored.
- Alignment pipeline: issued x, y and valid delayed ROM_LATENCY stages. At the final stage the colour mux picks start_q/game_q/end_q/fill_colour from the latched scene. x, y, colour and plot are registered from that stage.
- start while busy: ignored; latched scene is unaffected.
- abort in FETCH or DRAIN: next cycle is IDLE with busy=0 and plot=0. Pipeline valid bits flush, so no further plots. done does not pulse. The adapter keeps already-written pixels.
- reset (any time): asynchronous. State=IDLE. rom_address, x, y, colour=0. plot, busy, done=0. Latched scene=0. Pipeline cleared.

## Timing
- Reset values: every output 0.
- Cycle numbering: cycle 0 is the cycle in which start is sampled in IDLE.
- rom_address = k-1 and busy=1 in cycle k, for k=1..N.
- ROM data for that address is valid in cycle k+ROM_LATENCY. It is registered, so pixel n plots in cycle n+ROM_LATENCY+2.
- First plot is in cycle ROM_LATENCY+2; last plot is in cycle N+ROM_LATENCY+1. plot stays high continuously between them.
- done=1 and busy=0 in cycle N+ROM_LATENCY+2. The earliest next accepted start is in cycle N+ROM_LATENCY+3.
- Throughput: one pixel per clock. Total sweep for defaults with ROM_LATENCY=1 is 19203 cycles.
- Scene 3 uses identical timing; ROM outputs are ignored.

## Test plan
- Small build (WIDTH=4, HEIGHT=3, ROM_LATENCY=1), ROM models return the address as data, start pulse with scene=1:
  - exactly 12 plots, in cycles 3..14;
  - (x,y) sequence (0,0),(1,0)..(3,0),(0,1)..(3,2);
  - colour equals 0..11;
  - done=1 only in cycle 15; busy high in cycles 1..14.
- scene=3, fill_colour=12'hF0A: all 12 plots carry 12'hF0A while ROM data toggles. The scene=3 start is then held high for 3 cycles mid-sweep with scene=0: still 12 plots, colour unchanged, no restart.
- ROM_LATENCY=2, default size, scene=2: first plot (0,0) in cycle 4; last plot (159,119) colour=end_q of address 19199 in cycle 19203; done in cycle 19204.
- Abort asserted in cycle 6 of a small-build sweep:
  - the last plot seen is in cycle 6 (plotting address 3);
  - plot=0 and busy=0 from cycle 7;
  - done never pulses;
  - a new start then produces a full 12-pixel sweep.
- reset asserted asynchronously mid-sweep: all outputs 0 immediately, with no clock edge required. After release the block sits in IDLE until start.
- start and abort high together in IDLE: no busy, no plot. start pulsed during DONE: ignored, busy stays 0.

Source files
------------

// File: rtl/frame_draw_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_draw_ctrl                                                          |
// | Full-screen redraw sequencer: sweeps ROM / fill colour into VGA adapter. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module frame_draw_ctrl #(
   parameter int WIDTH       = 160,
   parameter int HEIGHT      = 120,
   parameter int ADDR_WIDTH  = 15,
   parameter int ROM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [1:0]            scene,
   input  logic [11:0]           fill_colour,
   input  logic [11:0]           start_q,
   input  logic [11:0]           game_q,
   input  logic [11:0]           end_q,
   output logic [ADDR_WIDTH-1:0] rom_address,
   output logic [7:0]            x,
   output logic [6:0]            y,
   output logic [11:0]           colour,
   output logic                  plot,
   output logic                  busy,
   output logic                  done
);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_fetch = 2'd1;
   localparam logic [1:0] c_drain = 2'd2;
   localparam logic [1:0] c_done  = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] c_addr_last = ADDR_WIDTH'(WIDTH*HEIGHT-1);
   localparam logic [7:0]            c_x_last    = 8'(WIDTH-1);

   logic [1:0]  r_state;
   logic [1:0]  w_next;
   logic [1:0]  r_scene;
   logic [11:0] r_fill;
   logic [7:0]  r_iss_x;
   logic [6:0]  r_iss_y;
   logic        r_iss_valid;
   logic [ROM_LATENCY-1:0][7:0] r_pipe_x;
   logic [ROM_LATENCY-1:0][6:0] r_pipe_y;
   logic [ROM_LATENCY-1:0]      r_pipe_valid;
   logic        w_accept;
   logic        w_abort;
   logic        w_last_issue;
   logic        w_pipe_empty;
   logic [11:0] w_colour;

   assign w_accept     = (r_state == c_idle) && start && !abort;
   assign w_abort      = abort && ((r_state == c_fetch) || (r_state == c_drain));
   assign w_last_issue = (r_state == c_fetch) && (rom_address == c_addr_last);
   // Once nothing is left upstream, the last pixel is sitting in the output register.
   assign w_pipe_empty = !r_iss_valid && (r_pipe_valid == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= c_idle;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle:  if (w_accept) w_next = c_fetch;
         c_fetch: begin
            if (abort)             w_next = c_idle;
            else if (w_last_issue) w_next = c_drain;
         end
         c_drain: begin
            if (abort)             w_next = c_idle;
            else if (w_pipe_empty) w_next = c_done;
         end
         c_done:  w_next = c_idle;
         default: w_next = c_idle;
      endcase
   end

   always_comb begin
      busy = (r_state == c_fetch) || (r_state == c_drain);
      done = (r_state == c_done);
   end

   // Issue stage: address and x/y advance together, so address tracks y*WIDTH+x.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rom_address <= '0;
         r_iss_x     <= '0;
         r_iss_y     <= '0;
         r_iss_valid <= 1'b0;
         r_scene     <= 2'd0;
         r_fill      <= 12'd0;
      end else if (w_accept) begin
         rom_address <= '0;
         r_iss_x     <= '0;
         r_iss_y     <= '0;
         r_iss_valid <= 1'b1;
         r_scene     <= scene;
         r_fill      <= fill_colour;
      end else if ((r_state == c_fetch) && !abort && !w_last_issue) begin
         rom_address <= rom_address + ADDR_WIDTH'(1);
         r_iss_valid <= 1'b1;
         if (r_iss_x == c_x_last) begin
            r_iss_x <= '0;
            r_iss_y <= r_iss_y + 7'd1;
         end else begin
            r_iss_x <= r_iss_x + 8'd1;
         end
      end else begin
         rom_address <= '0;
         r_iss_valid <= 1'b0;
      end
   end

   always_comb begin
      w_colour = r_fill;
      case (r_scene)
         2'd0:    w_colour = start_q;
         2'd1:    w_colour = game_q;
         2'd2:    w_colour = end_q;
         default: w_colour = r_fill;
      endcase
   end

   // Delay line matching ROM latency; abort kills every in-flight valid bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pipe_x     <= '0;
         r_pipe_y     <= '0;
         r_pipe_valid <= '0;
         x            <= 8'd0;
         y            <= 7'd0;
         colour       <= 12'd0;
         plot         <= 1'b0;
      end else begin
         r_pipe_x[0]     <= r_iss_x;
         r_pipe_y[0]     <= r_iss_y;
         r_pipe_valid[0] <= r_iss_valid && !w_abort;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            r_pipe_x[i]     <= r_pipe_x[i-1];
            r_pipe_y[i]     <= r_pipe_y[i-1];
            r_pipe_valid[i] <= r_pipe_valid[i-1] && !w_abort;
         end
         x      <= r_pipe_x[ROM_LATENCY-1];
         y      <= r_pipe_y[ROM_LATENCY-1];
         colour <= w_colour;
         plot   <= r_pipe_valid[ROM_LATENCY-1] && !w_abort;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_frame_draw_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_frame_draw_ctrl                                                       |
// | Bench for frame_draw_ctrl: small 4x3 build and default-size build.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_frame_draw_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        s_start, s_abort;
   logic [1:0]  s_scene;
   logic [11:0] s_fill;
   logic [11:0] s_start_q, s_game_q, s_end_q;
   logic [3:0]  s_addr;
   logic [7:0]  s_x;
   logic [6:0]  s_y;
   logic [11:0] s_colour;
   logic        s_plot, s_busy, s_done;

   frame_draw_ctrl #(.WIDTH(4), .HEIGHT(3), .ADDR_WIDTH(4), .ROM_LATENCY(1)) u_small (
      .clk(clk), .reset(reset), .start(s_start), .abort(s_abort), .scene(s_scene),
      .fill_colour(s_fill), .start_q(s_start_q), .game_q(s_game_q), .end_q(s_end_q),
      .rom_address(s_addr), .x(s_x), .y(s_y), .colour(s_colour), .plot(s_plot),
      .busy(s_busy), .done(s_done)
   );

   // Registered ROMs with distinct offsets so a wrong scene select is visible.
   always @(posedge clk) begin
      s_start_q <= 12'h100 + 12'(s_addr);
      s_game_q  <= 12'(s_addr);
      s_end_q   <= 12'h200 + 12'(s_addr);
   end

   logic        b_start, b_abort;
   logic [1:0]  b_scene;
   logic [11:0] b_fill, b_start_q, b_game_q, b_end_q;
   logic [14:0] b_addr, b_d1;
   logic [7:0]  b_x;
   logic [6:0]  b_y;
   logic [11:0] b_colour;
   logic        b_plot, b_busy, b_done;

   frame_draw_ctrl #(.ROM_LATENCY(2)) u_big (
      .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .scene(b_scene),
      .fill_colour(b_fill), .start_q(b_start_q), .game_q(b_game_q), .end_q(b_end_q),
      .rom_address(b_addr), .x(b_x), .y(b_y), .colour(b_colour), .plot(b_plot),
      .busy(b_busy), .done(b_done)
   );

   assign b_start_q = 12'h0F0;
   assign b_game_q  = 12'h00F;
   always @(posedge clk) begin
      b_d1    <= b_addr;
      b_end_q <= b_d1[11:0];
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int exp_col(input int sc, input int fill, input int p);
      case (sc)
         0:       return 'h100 + p;
         1:       return p;
         2:       return 'h200 + p;
         default: return fill;
      endcase
   endfunction

   // Runs one small-build sequence from cycle 0 (start) and gathers statistics.
   task automatic run_small(input int sc, input int fill, input int abort_at, input bit extra,
                            input int ncyc, output int plots, output int first_c,
                            output int last_c, output int done_n, output int done_c,
                            output int bad, output int busy_bad);
      bit exp_busy;
      plots = 0; first_c = -1; last_c = -1; done_n = 0; done_c = -1; bad = 0; busy_bad = 0;
      for (int c = 0; c < ncyc; c++) begin
         s_start = (c == 0) || (extra && ((c >= 5 && c <= 7) || c == 15));
         s_scene = (c == 0) ? 2'(sc) : 2'd0;
         s_fill  = (c == 0) ? 12'(fill) : 12'h123;
         s_abort = (c == abort_at);
         @(negedge clk);
         if (s_plot) begin
            if (int'(s_x) != plots % 4 || int'(s_y) != plots / 4 ||
                int'(s_colour) != exp_col(sc, fill, plots) || c != plots + 3)
               bad++;
            if (first_c < 0) first_c = c;
            last_c = c;
            plots++;
         end
         if (s_done) begin
            done_n++;
            done_c = c;
         end
         exp_busy = (abort_at < 0) ? (c >= 1 && c <= 14) : (c >= 1 && c <= abort_at);
         if (s_busy != exp_busy) busy_bad++;
         @(posedge clk); #1;
      end
      s_start = 1'b0;
      s_abort = 1'b0;
   endtask

   typedef struct {
      logic        start;
      logic [1:0]  scene;
      logic        e_busy, e_plot, e_done;
      int          e_addr, e_x, e_y, e_col;
   } vec_t;

   vec_t vecs[17];

   initial begin
      int plots, first_c, last_c, done_n, done_c, bad, busy_bad, cnt;
      int b_first, b_last, b_done_c, b_cnt, fx, fy, lx, ly, lcol;

      reset = 1'b1;
      s_start = 0; s_abort = 0; s_scene = 0; s_fill = 0;
      b_start = 0; b_abort = 0; b_scene = 2'd2; b_fill = 12'h000;
      #1;
      check("reset busy", s_busy, 0);
      check("reset plot", s_plot, 0);
      check("reset done", s_done, 0);
      check("reset addr", s_addr, 0);
      check("reset xyc", {s_x, s_y, s_colour}, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      for (int c = 0; c < 17; c++) begin
         int p;
         p = c - 3;
         vecs[c].start  = (c == 0);
         vecs[c].scene  = 2'd1;
         vecs[c].e_busy = (c >= 1 && c <= 14);
         vecs[c].e_plot = (c >= 3 && c <= 14);
         vecs[c].e_done = (c == 15);
         vecs[c].e_addr = (c >= 1 && c <= 12) ? c - 1 : 0;
         vecs[c].e_x    = (p >= 0) ? p % 4 : 0;
         vecs[c].e_y    = (p >= 0) ? p / 4 : 0;
         vecs[c].e_col  = p;
      end

      for (int c = 0; c < 17; c++) begin
         s_start = vecs[c].start;
         s_scene = vecs[c].scene;
         @(negedge clk);
         check($sformatf("v%0d busy", c), s_busy, vecs[c].e_busy);
         check($sformatf("v%0d plot", c), s_plot, vecs[c].e_plot);
         check($sformatf("v%0d done", c), s_done, vecs[c].e_done);
         check($sformatf("v%0d addr", c), s_addr, vecs[c].e_addr);
         if (vecs[c].e_plot) begin
            check($sformatf("v%0d x", c), s_x, vecs[c].e_x);
            check($sformatf("v%0d y", c), s_y, vecs[c].e_y);
            check($sformatf("v%0d colour", c), s_colour, vecs[c].e_col);
         end
         @(posedge clk); #1;
      end
      s_start = 1'b0;

      // Fill scene, start held mid-sweep with another scene, start during DONE.
      run_small(3, 'hF0A, -1, 1'b1, 20, plots, first_c, last_c, done_n, done_c, bad, busy_bad);
      check("fill plots", plots, 12);
      check("fill first", first_c, 3);
      check("fill last", last_c, 14);
      check("fill done count", done_n, 1);
      check("fill done cycle", done_c, 15);
      check("fill pixel errors", bad, 0);
      check("fill busy errors", busy_bad, 0);

      run_small(1, 0, 6, 1'b0, 20, plots, first_c, last_c, done_n, done_c, bad, busy_bad);
      check("abort plots", plots, 4);
      check("abort last cycle", last_c, 6);
      check("abort done count", done_n, 0);
      check("abort pixel errors", bad, 0);
      check("abort busy errors", busy_bad, 0);

      run_small(0, 0, -1, 1'b0, 18, plots, first_c, last_c, done_n, done_c, bad, busy_bad);
      check("post-abort plots", plots, 12);
      check("post-abort done cycle", done_c, 15);
      check("post-abort pixel errors", bad, 0);
      check("post-abort busy errors", busy_bad, 0);

      s_start = 1'b1; s_abort = 1'b1; s_scene = 2'd1;
      @(posedge clk); #1;
      s_start = 1'b0; s_abort = 1'b0;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (s_busy || s_plot || s_done) cnt++;
         @(posedge clk); #1;
      end
      check("start+abort idle", cnt, 0);

      for (int c = 0; c <= 8; c++) begin
         s_start = (c == 0);
         s_scene = 2'd1;
         @(negedge clk);
         if (c < 8) begin
            @(posedge clk); #1;
         end
      end
      s_start = 1'b0;
      check("pre-reset plot", s_plot, 1);
      check("pre-reset x", s_x, 1);
      check("pre-reset y", s_y, 1);
      #2 reset = 1'b1;
      #1;
      check("async reset busy", s_busy, 0);
      check("async reset plot", s_plot, 0);
      check("async reset addr", s_addr, 0);
      check("async reset xyc", {s_x, s_y, s_colour}, 0);
      @(posedge clk); #1 reset = 1'b0;
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (s_busy || s_plot || s_done || s_addr != 0) cnt++;
         @(posedge clk); #1;
      end
      check("post-reset idle", cnt, 0);
      run_small(2, 0, -1, 1'b0, 17, plots, first_c, last_c, done_n, done_c, bad, busy_bad);
      check("post-reset plots", plots, 12);
      check("post-reset pixel errors", bad, 0);
      check("post-reset done cycle", done_c, 15);

      // Default size, two-cycle ROM latency, end screen.
      b_first = -1; b_last = -1; b_done_c = -1; b_cnt = 0;
      fx = -1; fy = -1; lx = -1; ly = -1; lcol = -1;
      for (int c = 0; c < 19300 && b_done_c < 0; c++) begin
         b_start = (c == 0);
         @(negedge clk);
         if (b_plot) begin
            if (b_first < 0) begin
               b_first = c; fx = b_x; fy = b_y;
            end
            b_last = c; lx = b_x; ly = b_y; lcol = b_colour;
            b_cnt++;
         end
         if (b_done) b_done_c = c;
         @(posedge clk); #1;
      end
      b_start = 1'b0;
      check("big first cycle", b_first, 4);
      check("big first xy", fx * 256 + fy, 0);
      check("big last cycle", b_last, 19203);
      check("big last x", lx, 159);
      check("big last y", ly, 119);
      check("big last colour", lcol, 19199 % 4096);
      check("big plot count", b_cnt, 19200);
      check("big done cycle", b_done_c, 19204);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
